decode_issue_stage: RTL and testbench
=====================================

// Module: decode_issue_stage
// PURPOSE
//  Decode/issue stage between the IF/ID latch and the execute stage. Drives the
//  register file read selects and captures operands. A 32-entry pending-write
//  scoreboard holds RAW/WAW hazards until writeback. Same-cycle writeback data
//  bypasses the register file. Results go into a single ID/EX holding register
//  with a valid/ready handshake.
// PARAMETERS
//  NREGS   32  architectural registers (entry 0 hardwired, never pending)
//  RAW_JAL 31  destination register index for JAL
// PORTS
//  CLK       in   1   clock, rising edge
//  nRST      in   1   reset, asynchronous, active-low
//  if_valid  in   1   IF/ID holds a valid instruction
//  if_ready  out  1   instruction accepted this cycle (fire = if_valid & if_ready)
//  if_instr  in   32  instruction word
//  if_pc     in   32  PC of instruction
//  rsel1     out  5   register file read select A = instr[25:21] (rs)
//  rsel2     out  5   register file read select B = instr[20:16] (rt)
//  rdat1     in   32  register file read data A (combinational)
//  rdat2     in   32  register file read data B (combinational)
//  wb_wen    in   1   writeback write enable (same signal driven to register file WEN)
//  wb_wsel   in   5   writeback register index
//  wb_wdat   in   32  writeback data
//  flush     in   1   kill ID/EX holding register and refuse issue this cycle
//  ex_valid  out  1   ID/EX register holds valid instruction
//  ex_ready  in   1   execute consumes ID/EX contents this cycle
//  ex_instr  out  32  held instruction;  ex_pc out 32 held PC
//  ex_rdat1  out  32  operand A;  ex_rdat2 out 32 operand B
//  ex_wsel   out  5   decoded destination;  ex_wen out 1 destination valid
//  stall     out  1   if_valid & ~if_ready (performance/debug)
// BEHAVIOUR
//  Reset (async, nRST=0): ex_valid=0, all ex_* data=0, all scoreboard bits=0.
//   Reset mid-operation drops the held instruction; no pending bits survive.
//  Decode (combinational on if_instr):
//   dest: opcode 0 -> rd (SLL/ALU/JR; JR: none); I-type ALU, LUI, loads -> rt;
//   JAL -> RAW_JAL; stores, BEQ/BNE, J, JR, HALT -> none. dest==0 -> none.
//   uses_rs: all except J, JAL, LUI, HALT. uses_rt: R-type, stores, BEQ, BNE.
//  Bypass: operand X = wb_wdat if wb_wen & wb_wsel==rselX & rselX!=0, else rdatX.
//  Source ready: unused, or index 0, or pending bit clear, or being written back
//   this cycle (wb_wen & wb_wsel==index).
//  Dest ready: none, or pending bit clear, or cleared this cycle (WAW stall otherwise).
//  if_ready = ~flush & srcs ready & dest ready & (~ex_valid | ex_ready).
//  Latency: accept at edge N -> ex_valid=1 in cycle N+1 with captured operands.
//  Holding register: on fire load ex_*, ex_valid=1; else if ex_ready clear
//   ex_valid; else hold all ex_* stable (backpressure: no change while ex_ready=0).
//  Scoreboard, per edge, in priority order:
//   1 clear bit wb_wsel when wb_wen (bit 0 never set);
//   2 on flush with ex_valid & ex_wen & ~ex_ready: clear bit ex_wsel;
//   3 on fire with dest: set bit dest (set wins over same-edge clear).
//  Flush: ex_valid->0 next edge unless ex_ready also high (then consumed
//   normally, bits untouched); if_ready=0 that cycle. Only ID/EX is flushable;
//   instructions past EX always write back, so at most one writer per register.
//  Write to register 0 by writeback: ignored by scoreboard and bypass.
// STRUCTURE
//  cpu_types_pkg: opcode_t/funct_t enums, regbits_t (5b), word_t, typedef struct
//   id_ex_t {instr, pc, rdat1, rdat2, wsel, wen}, localparam JAL_REG=31.
//  Sub-module reg_scoreboard: NREGS pending bits, set/clear/flush-clear ports,
//   two source lookup ports and one dest lookup port, async reset.
//  Top: decoder + bypass muxes + issue logic + id_ex_t holding register.
// TESTING
//  RAW: issue ADDU $3,$1,$2 then ADDU $4,$3,$3 -> second stalls (if_ready=0)
//   until wb_wen=1,wb_wsel=3,wb_wdat=0x55; accepted that cycle, ex_rdat1=ex_rdat2=0x55.
//  Bypass: rdat1=0x10 but wb_wen=1,wb_wsel=rs=5,wb_wdat=0x99 -> ex_rdat1=0x99.
//  Reg 0: ADDU $0,$1,$1 then ADDU $2,$0,$0 -> no stall, ex_wen=0 for first.
//  Backpressure: ex_ready=0 for 4 cycles -> ex_* constant, if_ready=0, ex_valid=1.
//  Flush: held LW $7 with ex_ready=0, flush=1 -> ex_valid=0, bit 7 cleared;
//   next ADDU $8,$7,$0 issues without stall.
//  Reset mid-op: pending bits 3,7 set, nRST pulse -> ex_valid=0, no stalls after.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types, opcodes and the decode helper
// Purpose: opcode/funct enums, register/word types, the ID/EX holding
//   register layout and a combinational decoder for destination/source usage.
// Ports: none (package).
package cpu_types_pkg;

  localparam int NREGS   = 32;
  localparam int JAL_REG = 31;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
    OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E,
    OP_LUI   = 6'h0F, OP_LB   = 6'h20, OP_LH    = 6'h21, OP_LW   = 6'h23,
    OP_LBU   = 6'h24, OP_LHU  = 6'h25, OP_SB    = 6'h28, OP_SH   = 6'h29,
    OP_SW    = 6'h2B, OP_HALT = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08, FN_ADD = 6'h20,
    FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
    FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  typedef struct packed {
    word_t    instr;
    word_t    pc;
    word_t    rdat1;
    word_t    rdat2;
    regbits_t wsel;
    logic     wen;
  } id_ex_t;

  typedef struct packed {
    regbits_t dest;
    logic     has_dest;
    logic     uses_rs;
    logic     uses_rt;
  } dec_t;

  function automatic dec_t decode(input word_t instr);
    dec_t    d;
    opcode_t op;
    op         = opcode_t'(instr[31:26]);
    d.dest     = '0;
    d.has_dest = 1'b0;
    d.uses_rs  = 1'b1;
    d.uses_rt  = 1'b0;
    case (op)
      OP_RTYPE: begin
        d.uses_rt  = 1'b1;
        d.dest     = instr[15:11];
        d.has_dest = (funct_t'(instr[5:0]) != FN_JR);
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        d.dest     = instr[20:16];
        d.has_dest = 1'b1;
      end
      OP_LUI: begin
        d.uses_rs  = 1'b0;
        d.dest     = instr[20:16];
        d.has_dest = 1'b1;
      end
      OP_JAL: begin
        d.uses_rs  = 1'b0;
        d.dest     = regbits_t'(JAL_REG);
        d.has_dest = 1'b1;
      end
      OP_J, OP_HALT: d.uses_rs = 1'b0;
      OP_SB, OP_SH, OP_SW, OP_BEQ, OP_BNE: d.uses_rt = 1'b1;
      default: ;
    endcase
    // Writes to $0 are discarded, so they never create a hazard.
    if (d.dest == '0) d.has_dest = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write scoreboard for RAW/WAW hazard detection
// Purpose: one pending bit per architectural register; set at issue, cleared
//   at writeback or when the ID/EX holder is flushed.
// Ports: CLK/nRST; wb_en_i/wb_idx_i writeback clear; fclr_en_i/fclr_idx_i
//   flush clear; set_en_i/set_idx_i issue set; src1/src2 lookups (idx, use,
//   rdy); dst lookup (idx, en, rdy).
module reg_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int NREGS_P = NREGS
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     wb_en_i,
  input  regbits_t wb_idx_i,
  input  logic     fclr_en_i,
  input  regbits_t fclr_idx_i,
  input  logic     set_en_i,
  input  regbits_t set_idx_i,
  input  regbits_t src1_idx_i,
  input  logic     src1_use_i,
  output logic     src1_rdy_o,
  input  regbits_t src2_idx_i,
  input  logic     src2_use_i,
  output logic     src2_rdy_o,
  input  regbits_t dst_idx_i,
  input  logic     dst_en_i,
  output logic     dst_rdy_o
);

  logic [NREGS_P-1:0] pend_q, pend_d;

  // A register being written back this cycle is effectively free already.
  function automatic logic wb_hit(input regbits_t idx);
    return wb_en_i && (wb_idx_i == idx);
  endfunction

  assign src1_rdy_o = !src1_use_i || (src1_idx_i == '0) || !pend_q[src1_idx_i] || wb_hit(src1_idx_i);
  assign src2_rdy_o = !src2_use_i || (src2_idx_i == '0) || !pend_q[src2_idx_i] || wb_hit(src2_idx_i);
  assign dst_rdy_o  = !dst_en_i   || !pend_q[dst_idx_i] || wb_hit(dst_idx_i);

  // Later assignments win: set from a new issue overrides a same-edge clear.
  always_comb begin
    pend_d = pend_q;
    if (wb_en_i)   pend_d[wb_idx_i]   = 1'b0;
    if (fclr_en_i) pend_d[fclr_idx_i] = 1'b0;
    if (set_en_i)  pend_d[set_idx_i]  = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) pend_q <= '0;
    else       pend_q <= pend_d;
  end

endmodule

// File: rtl/decode_issue_stage.sv
// rtl/decode_issue_stage.sv - decode, hazard check, bypass and ID/EX holding register
// Purpose: decodes the IF/ID instruction, reads operands (with same-cycle
//   writeback bypass), stalls on scoreboard hazards and issues into a single
//   ID/EX register with valid/ready handshake.
// Ports: CLK/nRST; if_valid/if_ready/if_instr/if_pc from IF/ID; rsel1/rsel2,
//   rdat1/rdat2 register file; wb_wen/wb_wsel/wb_wdat writeback; flush;
//   ex_valid/ex_ready and ex_* held fields to execute; stall debug.
module decode_issue_stage
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     if_valid,
  output logic     if_ready,
  input  word_t    if_instr,
  input  word_t    if_pc,
  output regbits_t rsel1,
  output regbits_t rsel2,
  input  word_t    rdat1,
  input  word_t    rdat2,
  input  logic     wb_wen,
  input  regbits_t wb_wsel,
  input  word_t    wb_wdat,
  input  logic     flush,
  output logic     ex_valid,
  input  logic     ex_ready,
  output word_t    ex_instr,
  output word_t    ex_pc,
  output word_t    ex_rdat1,
  output word_t    ex_rdat2,
  output regbits_t ex_wsel,
  output logic     ex_wen,
  output logic     stall
);

  dec_t   dec;
  id_ex_t ex_q, ex_d;
  logic   ex_valid_q, ex_valid_d;
  logic   src1_rdy, src2_rdy, dst_rdy;
  logic   fire, flush_clr;
  word_t  op1, op2;

  assign dec   = decode(if_instr);
  assign rsel1 = if_instr[25:21];
  assign rsel2 = if_instr[20:16];

  assign op1 = (wb_wen && (wb_wsel == rsel1) && (rsel1 != '0)) ? wb_wdat : rdat1;
  assign op2 = (wb_wen && (wb_wsel == rsel2) && (rsel2 != '0)) ? wb_wdat : rdat2;

  assign if_ready = !flush && src1_rdy && src2_rdy && dst_rdy && (!ex_valid_q || ex_ready);
  assign fire     = if_valid && if_ready;
  assign stall    = if_valid && !if_ready;

  // A killed instruction never reaches writeback, so its pending bit must go now.
  assign flush_clr = flush && ex_valid_q && ex_q.wen && !ex_ready;

  reg_scoreboard u_sb (
    .CLK        (CLK),
    .nRST       (nRST),
    .wb_en_i    (wb_wen),
    .wb_idx_i   (wb_wsel),
    .fclr_en_i  (flush_clr),
    .fclr_idx_i (ex_q.wsel),
    .set_en_i   (fire && dec.has_dest),
    .set_idx_i  (dec.dest),
    .src1_idx_i (rsel1),
    .src1_use_i (dec.uses_rs),
    .src1_rdy_o (src1_rdy),
    .src2_idx_i (rsel2),
    .src2_use_i (dec.uses_rt),
    .src2_rdy_o (src2_rdy),
    .dst_idx_i  (dec.dest),
    .dst_en_i   (dec.has_dest),
    .dst_rdy_o  (dst_rdy)
  );

  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (fire) begin
      ex_d.instr = if_instr;
      ex_d.pc    = if_pc;
      ex_d.rdat1 = op1;
      ex_d.rdat2 = op2;
      ex_d.wsel  = dec.dest;
      ex_d.wen   = dec.has_dest;
      ex_valid_d = 1'b1;
    end else if (ex_ready || flush) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_instr = ex_q.instr;
  assign ex_pc    = ex_q.pc;
  assign ex_rdat1 = ex_q.rdat1;
  assign ex_rdat2 = ex_q.rdat2;
  assign ex_wsel  = ex_q.wsel;
  assign ex_wen   = ex_q.wen;

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb/tb_decode_issue_stage.sv - directed self-checking bench for decode_issue_stage
module tb_decode_issue_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rsel1, rsel2;
  logic [31:0] rdat1, rdat2;
  logic        wb_wen;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_instr, ex_pc, ex_rdat1, ex_rdat2;
  logic [4:0]  ex_wsel;
  logic        ex_wen, stall;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  decode_issue_stage dut (
    .CLK(CLK), .nRST(nRST),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1), .rdat2(rdat2),
    .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr), .ex_pc(ex_pc),
    .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2), .ex_wsel(ex_wsel), .ex_wen(ex_wen),
    .stall(stall)
  );

  function automatic logic [31:0] addu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h21};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rt, input logic [4:0] rs);
    return {6'h23, rs, rt, 16'h0000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    rdat1 = '0; rdat2 = '0; wb_wen = 1'b0; wb_wsel = '0; wb_wdat = '0;
    flush = 1'b0; ex_ready = 1'b1;
    tick(); tick();
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_instr", ex_instr, 32'd0);
    chk("rst_ex_rdat1", ex_rdat1, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
    nRST = 1'b1;
    tick();

    // RAW hazard resolved by same-cycle writeback
    if_valid = 1'b1; if_instr = addu(5'd3, 5'd1, 5'd2); if_pc = 32'h100;
    rdat1 = 32'h11; rdat2 = 32'h22;
    #1 chk("raw_first_ready", {31'd0, if_ready}, 32'd1);
    chk("raw_rsel1", {27'd0, rsel1}, 32'd1);
    chk("raw_rsel2", {27'd0, rsel2}, 32'd2);
    tick();
    chk("raw_first_valid", {31'd0, ex_valid}, 32'd1);
    chk("raw_first_rdat1", ex_rdat1, 32'h11);
    chk("raw_first_rdat2", ex_rdat2, 32'h22);
    chk("raw_first_wsel", {27'd0, ex_wsel}, 32'd3);
    chk("raw_first_pc", ex_pc, 32'h100);
    if_instr = addu(5'd4, 5'd3, 5'd3); if_pc = 32'h104; rdat1 = '0; rdat2 = '0;
    #1 chk("raw_stall_ready", {31'd0, if_ready}, 32'd0);
    chk("raw_stall_flag", {31'd0, stall}, 32'd1);
    tick();
    chk("raw_drained", {31'd0, ex_valid}, 32'd0);
    chk("raw_still_stall", {31'd0, if_ready}, 32'd0);
    wb_wen = 1'b1; wb_wsel = 5'd3; wb_wdat = 32'h55;
    #1 chk("raw_wb_ready", {31'd0, if_ready}, 32'd1);
    tick();
    wb_wen = 1'b0;
    chk("raw_byp_rdat1", ex_rdat1, 32'h55);
    chk("raw_byp_rdat2", ex_rdat2, 32'h55);
    chk("raw_second_wsel", {27'd0, ex_wsel}, 32'd4);

    // Bypass on operand A
    if_instr = addu(5'd6, 5'd5, 5'd0); rdat1 = 32'h10; rdat2 = 32'h7;
    wb_wen = 1'b1; wb_wsel = 5'd5; wb_wdat = 32'h99;
    #1 chk("byp_ready", {31'd0, if_ready}, 32'd1);
    tick();
    wb_wen = 1'b0;
    chk("byp_rdat1", ex_rdat1, 32'h99);
    chk("byp_rdat2", ex_rdat2, 32'h7);

    // Register 0 destination and sources
    if_instr = addu(5'd0, 5'd1, 5'd1);
    #1 chk("r0_first_ready", {31'd0, if_ready}, 32'd1);
    tick();
    chk("r0_first_wen", {31'd0, ex_wen}, 32'd0);
    chk("r0_first_valid", {31'd0, ex_valid}, 32'd1);
    if_instr = addu(5'd2, 5'd0, 5'd0);
    #1 chk("r0_second_ready", {31'd0, if_ready}, 32'd1);
    tick();
    chk("r0_second_wen", {31'd0, ex_wen}, 32'd1);
    chk("r0_second_wsel", {27'd0, ex_wsel}, 32'd2);

    // Backpressure: holder frozen for 4 cycles
    ex_ready = 1'b0; if_instr = addu(5'd9, 5'd1, 5'd1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_if_ready", {31'd0, if_ready}, 32'd0);
      chk("bp_ex_valid", {31'd0, ex_valid}, 32'd1);
      chk("bp_ex_instr", ex_instr, addu(5'd2, 5'd0, 5'd0));
      chk("bp_ex_wsel", {27'd0, ex_wsel}, 32'd2);
      tick();
    end
    ex_ready = 1'b1;
    #1 chk("bp_release_ready", {31'd0, if_ready}, 32'd1);
    tick();
    chk("bp_next_instr", ex_instr, addu(5'd9, 5'd1, 5'd1));

    // Flush of a held load clears its pending bit
    if_instr = lw(5'd7, 5'd1);
    #1 chk("fl_lw_ready", {31'd0, if_ready}, 32'd1);
    tick();
    chk("fl_lw_wsel", {27'd0, ex_wsel}, 32'd7);
    chk("fl_lw_wen", {31'd0, ex_wen}, 32'd1);
    ex_ready = 1'b0; flush = 1'b1; if_instr = addu(5'd8, 5'd7, 5'd0);
    #1 chk("fl_flush_ready", {31'd0, if_ready}, 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_killed", {31'd0, ex_valid}, 32'd0);
    #1 chk("fl_no_stall", {31'd0, if_ready}, 32'd1);
    tick();
    chk("fl_issued_valid", {31'd0, ex_valid}, 32'd1);
    chk("fl_issued_instr", ex_instr, addu(5'd8, 5'd7, 5'd0));

    // JAL destination, WAW stall, then reset mid-operation
    ex_ready = 1'b1; if_instr = addu(5'd3, 5'd1, 5'd1);
    tick();
    if_instr = lw(5'd7, 5'd1);
    tick();
    if_instr = {6'h03, 26'h0000040};
    #1 chk("jal_ready", {31'd0, if_ready}, 32'd1);
    tick();
    chk("jal_wsel", {27'd0, ex_wsel}, 32'd31);
    chk("jal_wen", {31'd0, ex_wen}, 32'd1);
    if_instr = addu(5'd10, 5'd3, 5'd7);
    #1 chk("pre_rst_raw", {31'd0, if_ready}, 32'd0);
    if_instr = addu(5'd3, 5'd1, 5'd1);
    #1 chk("pre_rst_waw", {31'd0, if_ready}, 32'd0);
    nRST = 1'b0;
    #1 chk("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, if_ready}, 32'd1);
    nRST = 1'b1;
    if_instr = addu(5'd10, 5'd3, 5'd7);
    #1 chk("post_rst_ready", {31'd0, if_ready}, 32'd1);
    tick();
    chk("post_rst_wsel", {27'd0, ex_wsel}, 32'd10);
    if_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
